// File: rtl/dac_ramp_pdm_multi_pkg.sv
// Shared types and helpers for the multi-channel ramped PDM DAC front-end.
package dac_pkg;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_RISE,
    RS_FALL
  } ramp_state_t;

  // Extra bits carried above WIDTH so a sum can never wrap.
  localparam int unsigned EXT_BITS = 1;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One rising slew step, clamped at the target. A step of 0 jumps to the target.
  function automatic int unsigned step_up(input int unsigned code, input int unsigned step,
                                          input int unsigned target);
    int unsigned sum;
    if (step == 0) return target;
    sum = code + step;
    return (sum > target) ? target : sum;
  endfunction

  // One falling slew step, clamped at the target without going below zero.
  // A step of 0 jumps to the target.
  function automatic int unsigned step_down(input int unsigned code, input int unsigned step,
                                            input int unsigned target);
    if (step == 0) return target;
    if (code < target + step) return target;
    return code - step;
  endfunction

endpackage

// File: rtl/dac_ramp_pdm_multi_if.sv
// Write port for the DAC bank: valid/ready handshake carrying channel index and target code.
interface dac_ramp_pdm_multi_if
  import dac_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  localparam int CHW = chw(NCH);

  logic             wr_valid;
  logic             wr_ready;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_code;

  modport master (output wr_valid, output wr_ch, output wr_code, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_code, output wr_ready);
endinterface

// File: rtl/dac_ramp_pdm_multi_ch.sv
// One DAC channel: target register, slew FSM and 1st-order sigma-delta modulator.
module dac_ramp_ch
  import dac_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned RISE_STEP = 1,
  parameter int unsigned FALL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] code_o,
  output logic             busy_o,
  output logic             pdm_o
);

  localparam int SW = WIDTH + EXT_BITS;

  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] acc_q;
  logic             pdm_q;
  ramp_state_t      state_q;

  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [SW-1:0]    pdm_sum;

  assign rise_d  = WIDTH'(step_up(32'(code_q), RISE_STEP, 32'(target_q)));
  assign fall_d  = WIDTH'(step_down(32'(code_q), FALL_STEP, 32'(target_q)));
  assign pdm_sum = SW'(acc_q) + SW'(code_q);

  // Target register: a write lands at the edge it is accepted; the slew sees it one cycle later.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       target_q <= '0;
    else if (we_i) target_q <= wdata_i;
  end

  // Slew FSM: direction chosen from code vs. target, code moves only on ramp ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_IDLE;
      code_q  <= '0;
    end else begin
      case (state_q)
        RS_IDLE: begin
          if (code_q < target_q)      state_q <= RS_RISE;
          else if (code_q > target_q) state_q <= RS_FALL;
        end
        RS_RISE: begin
          if (code_q == target_q)     state_q <= RS_IDLE;
          else if (code_q > target_q) state_q <= RS_FALL;
          else if (tick_i)            code_q  <= rise_d;
        end
        RS_FALL: begin
          if (code_q == target_q)     state_q <= RS_IDLE;
          else if (code_q < target_q) state_q <= RS_RISE;
          else if (tick_i)            code_q  <= fall_d;
        end
        default: state_q <= RS_IDLE;
      endcase
    end
  end

  // Sigma-delta: accumulate the code each clock, the carry is the PDM bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= pdm_sum[WIDTH-1:0];
      pdm_q <= pdm_sum[WIDTH];
    end
  end

  assign code_o = code_q;
  assign busy_o = (code_q != target_q);
  assign pdm_o  = pdm_q;

endmodule

// File: rtl/dac_ramp_pdm_multi.sv
// Top of the DAC bank: ramp tick divider, write decode, write-ready and error flag.
module dac_ramp_pdm_multi
  import dac_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          WIDTH     = 8,
  parameter int unsigned RISE_STEP = 1,
  parameter int unsigned FALL_STEP = 1,
  parameter int          TICK_DIV  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_ramp_pdm_multi_if.slave    wr_if,
  output logic [NCH*WIDTH-1:0]   code_out_o,
  output logic [NCH-1:0]         ramp_busy_o,
  output logic [NCH-1:0]         pdm_out_o,
  output logic                   wr_err_o
);

  localparam int CHW  = chw(NCH);
  localparam int CNTW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

  logic [CNTW-1:0] cnt_q;
  logic            tick;
  logic            wr_ready_q;
  logic            wr_err_q;
  logic            wr_fire;
  logic            wr_in_range;
  logic [NCH-1:0]  we;

  assign tick        = (cnt_q == CNTW'(TICK_DIV - 1));
  assign wr_fire     = wr_if.wr_valid & wr_ready_q;
  assign wr_in_range = (32'(wr_if.wr_ch) < NCH);

  // Free-running ramp tick divider; writes never disturb it.
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // Write-ready rises one cycle after reset; out-of-range writes set a sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_ready_q <= 1'b1;
      if (wr_fire && !wr_in_range) wr_err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign we[i] = wr_fire && (wr_if.wr_ch == CHW'(i));

    dac_ramp_ch #(
      .WIDTH    (WIDTH),
      .RISE_STEP(RISE_STEP),
      .FALL_STEP(FALL_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .we_i   (we[i]),
      .wdata_i(wr_if.wr_code),
      .code_o (code_out_o[i*WIDTH +: WIDTH]),
      .busy_o (ramp_busy_o[i]),
      .pdm_o  (pdm_out_o[i])
    );
  end

  assign wr_if.wr_ready = wr_ready_q;
  assign wr_err_o       = wr_err_q;

endmodule
